// File: rtl/accum_writeback_ctrl.sv
// Drains one result tile from the accumulator into the unified buffer:
// read row -> requantize every lane -> write row once the shared port is granted.

module accum_writeback_lane #(
    parameter int RES_W = 32,
    parameter int ACT_W = 8
) (
    input  logic [RES_W-1:0] i_acc,
    input  logic [4:0]       i_shift,
    input  logic             i_relu,
    output logic [ACT_W-1:0] o_act
);
    localparam logic signed [RES_W-1:0] SAT_HI = RES_W'((64'sd1 <<< (ACT_W-1)) - 64'sd1);
    localparam logic signed [RES_W-1:0] SAT_LO = ~SAT_HI;

    logic signed [RES_W-1:0] w_sh;
    logic signed [RES_W-1:0] w_y;

    assign w_sh = $signed(i_acc) >>> i_shift;
    assign w_y  = (i_relu && w_sh[RES_W-1]) ? '0 : w_sh;

    always_comb begin
        o_act = w_y[ACT_W-1:0];
        if (w_y > SAT_HI)      o_act = SAT_HI[ACT_W-1:0];
        else if (w_y < SAT_LO) o_act = SAT_LO[ACT_W-1:0];
    end
endmodule

module accum_writeback_ctrl #(
    parameter int MUL_SIZE   = 32,
    parameter int RES_W      = 32,
    parameter int ACT_W      = 8,
    parameter int ACC_ADDR_W = 10,
    parameter int UB_ADDR_W  = 12
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [7:0]                        rows_i,
    input  logic [ACC_ADDR_W-1:0]             acc_base_i,
    input  logic [UB_ADDR_W-1:0]              ub_base_i,
    input  logic [4:0]                        shift_i,
    input  logic                              relu_en_i,
    output logic                              acc_rd_en_o,
    output logic [ACC_ADDR_W-1:0]             acc_addr_rd_o,
    input  logic [MUL_SIZE-1:0][RES_W-1:0]    acc_data_i,
    output logic                              ub_wr_en_o,
    input  logic                              ub_grant_i,
    output logic [UB_ADDR_W-1:0]              ub_addr_wr_o,
    output logic [MUL_SIZE-1:0][ACT_W-1:0]    ub_data_o,
    output logic                              busy_o,
    output logic                              done_o
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                         r_state;
    logic [7:0]                         r_rows;
    logic [7:0]                         r_iss_cnt;
    logic [7:0]                         r_wr_cnt;
    logic [1:0]                         r_credits;
    logic [4:0]                         r_shift;
    logic                               r_relu;
    logic [ACC_ADDR_W-1:0]              r_rd_addr;
    logic [UB_ADDR_W-1:0]               r_ub_ptr;
    // [0]: read data on acc_data_i this cycle, [1]: row parked in S1, [2]: S2 full
    logic [2:0]                         r_vld_pipe;
    logic [MUL_SIZE-1:0][RES_W-1:0]     r_s1_data;
    logic [MUL_SIZE-1:0][ACT_W-1:0]     r_s2_data;
    logic [UB_ADDR_W-1:0]               r_s2_addr;

    logic                               w_wr_done;
    logic                               w_issue;
    logic                               w_last_iss;
    logic                               w_last_wr;
    logic                               w_s1_avail;
    logic                               w_s2_adv;
    logic                               w_s2_load;
    logic [MUL_SIZE-1:0][RES_W-1:0]     w_s1_row;
    logic [MUL_SIZE-1:0][ACT_W-1:0]     w_rq;

    assign w_wr_done  = r_vld_pipe[2] & ub_grant_i;
    // A completing write frees its credit in the same cycle, keeping one row/cycle under full grant.
    assign w_issue    = (r_state == ST_ISSUE) && (r_iss_cnt != r_rows) &&
                        ((r_credits != 2'd0) || w_wr_done);
    assign w_last_iss = w_issue && (r_iss_cnt == r_rows - 8'd1);
    assign w_last_wr  = w_wr_done && (r_wr_cnt == r_rows - 8'd1);
    assign w_s1_avail = r_vld_pipe[0] | r_vld_pipe[1];
    assign w_s2_adv   = ~r_vld_pipe[2] | w_wr_done;
    assign w_s2_load  = w_s1_avail & w_s2_adv;
    assign w_s1_row   = r_vld_pipe[1] ? r_s1_data : acc_data_i;

    for (genvar g = 0; g < MUL_SIZE; g++) begin : g_lane
        accum_writeback_lane #(
            .RES_W (RES_W),
            .ACT_W (ACT_W)
        ) u_lane (
            .i_acc   (w_s1_row[g]),
            .i_shift (r_shift),
            .i_relu  (r_relu),
            .o_act   (w_rq[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_rows    <= '0;
            r_iss_cnt <= '0;
            r_wr_cnt  <= '0;
            r_credits <= 2'd2;
            r_shift   <= '0;
            r_relu    <= 1'b0;
            r_rd_addr <= '0;
            r_ub_ptr  <= '0;
        end else begin
            case ({w_issue, w_wr_done})
                2'b10:   r_credits <= r_credits - 2'd1;
                2'b01:   r_credits <= r_credits + 2'd1;
                default: r_credits <= r_credits;
            endcase
            if (w_issue) begin
                r_iss_cnt <= r_iss_cnt + 8'd1;
                r_rd_addr <= r_rd_addr + ACC_ADDR_W'(1);
            end
            if (w_wr_done) r_wr_cnt <= r_wr_cnt + 8'd1;
            if (w_s2_load) r_ub_ptr <= r_ub_ptr + UB_ADDR_W'(1);

            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_rows    <= rows_i;
                        r_shift   <= shift_i;
                        r_relu    <= relu_en_i;
                        r_rd_addr <= acc_base_i;
                        r_ub_ptr  <= ub_base_i;
                        r_iss_cnt <= '0;
                        r_wr_cnt  <= '0;
                        r_state   <= (rows_i == 8'd0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: if (w_last_iss) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_last_wr)  r_state <= ST_DONE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_vld_pipe <= '0;
            r_s1_data  <= '0;
            r_s2_data  <= '0;
            r_s2_addr  <= '0;
        end else begin
            r_vld_pipe[0] <= w_issue;
            r_vld_pipe[1] <= w_s1_avail & ~w_s2_adv;
            r_vld_pipe[2] <= w_s2_load | (r_vld_pipe[2] & ~w_wr_done);
            // Credits guarantee a parked row is never overwritten by a new return.
            if (r_vld_pipe[0]) r_s1_data <= acc_data_i;
            if (w_s2_load) begin
                r_s2_data <= w_rq;
                r_s2_addr <= r_ub_ptr;
            end
        end
    end

    assign acc_rd_en_o   = w_issue;
    assign acc_addr_rd_o = r_rd_addr;
    assign ub_wr_en_o    = r_vld_pipe[2];
    assign ub_addr_wr_o  = r_s2_addr;
    assign ub_data_o     = r_s2_data;
    assign busy_o        = (r_state != ST_IDLE);
    assign done_o        = (r_state == ST_DONE);
endmodule

// File: tb/tb_accum_writeback_ctrl.sv
// Directed bench for accum_writeback_ctrl: event log on the falling edge,
// hand-computed expectations per tile.

module tb_accum_writeback_ctrl;
    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 start_i;
    logic [7:0]           rows_i;
    logic [9:0]           acc_base_i;
    logic [11:0]          ub_base_i;
    logic [4:0]           shift_i;
    logic                 relu_en_i;
    logic                 acc_rd_en_o;
    logic [9:0]           acc_addr_rd_o;
    logic [31:0][31:0]    acc_data_i;
    logic                 ub_wr_en_o;
    logic                 ub_grant_i;
    logic [11:0]          ub_addr_wr_o;
    logic [31:0][7:0]     ub_data_o;
    logic                 busy_o;
    logic                 done_o;

    always #5 clk_i = ~clk_i;

    accum_writeback_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .rows_i(rows_i),
        .acc_base_i(acc_base_i), .ub_base_i(ub_base_i), .shift_i(shift_i),
        .relu_en_i(relu_en_i), .acc_rd_en_o(acc_rd_en_o), .acc_addr_rd_o(acc_addr_rd_o),
        .acc_data_i(acc_data_i), .ub_wr_en_o(ub_wr_en_o), .ub_grant_i(ub_grant_i),
        .ub_addr_wr_o(ub_addr_wr_o), .ub_data_o(ub_data_o), .busy_o(busy_o), .done_o(done_o)
    );

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int stall_en = 0;
    int lane_val[32];
    int row_step = 1;
    logic [9:0] g_acc_base = '0;

    int rd_cyc[$];
    int rd_addr[$];
    int wr_cyc[$];
    int wr_addr[$];
    logic [255:0] wr_data[$];
    int done_cyc[$];
    int viol_stall, viol_done, n_stall, outst, max_outst;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0][31:0] gen(input logic [9:0] a);
        logic [9:0] k;
        k = a - g_acc_base;
        for (int j = 0; j < 32; j++) gen[j] = 32'(lane_val[j] + int'(k) * row_step);
    endfunction

    function automatic logic [255:0] exp_row(input int k);
        logic [255:0] r;
        for (int j = 0; j < 32; j++) r[j*8 +: 8] = 8'(k);
        return r;
    endfunction

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // accumulator model: data valid exactly one cycle after the read strobe
    initial forever begin
        @(posedge clk_i);
        if (acc_rd_en_o) acc_data_i <= gen(acc_addr_rd_o);
        else             acc_data_i <= {32{32'hDEADBEEF}};
    end

    initial begin : grant_drv
        int g_rel;
        ub_grant_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            g_rel = cyc - t0;
            ub_grant_i = !(stall_en != 0 && g_rel >= 4 && g_rel <= 8);
        end
    end

    initial begin : monitor
        int rel;
        logic prev_stall;
        logic [11:0] prev_addr;
        logic [255:0] prev_data;
        prev_stall = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        forever begin
            @(negedge clk_i);
            rel = cyc - t0;
            if (acc_rd_en_o) begin
                rd_cyc.push_back(rel);
                rd_addr.push_back(int'(acc_addr_rd_o));
            end
            if (ub_wr_en_o && ub_grant_i) begin
                wr_cyc.push_back(rel);
                wr_addr.push_back(int'(ub_addr_wr_o));
                wr_data.push_back(ub_data_o);
            end
            if (done_o) done_cyc.push_back(rel);
            if (done_o && ub_wr_en_o) viol_done++;
            if (prev_stall && (!ub_wr_en_o || ub_addr_wr_o != prev_addr || ub_data_o != prev_data))
                viol_stall++;
            prev_stall = ub_wr_en_o && !ub_grant_i;
            if (prev_stall) n_stall++;
            prev_addr = ub_addr_wr_o;
            prev_data = ub_data_o;
            outst = outst + int'(acc_rd_en_o) - int'(ub_wr_en_o && ub_grant_i);
            if (outst > max_outst) max_outst = outst;
        end
    end

    task automatic start_tile(input int rows, input int accb, input int ubb,
                              input int sh, input bit relu);
        @(posedge clk_i);
        #1;
        rd_cyc.delete(); rd_addr.delete(); wr_cyc.delete();
        wr_addr.delete(); wr_data.delete(); done_cyc.delete();
        viol_stall = 0; viol_done = 0; n_stall = 0; outst = 0; max_outst = 0;
        t0 = cyc;
        g_acc_base = 10'(accb);
        start_i = 1'b1;
        rows_i = 8'(rows);
        acc_base_i = 10'(accb);
        ub_base_i = 12'(ubb);
        shift_i = 5'(sh);
        relu_en_i = relu;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        rows_i = 8'hFF;
        acc_base_i = 10'h155;
        ub_base_i = 12'hAAA;
        shift_i = 5'd31;
        relu_en_i = ~relu;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cyc.size() == 0 && n < 300) begin
            @(posedge clk_i);
            n++;
        end
        repeat (3) @(posedge clk_i);
        #1;
        chk("done_once", done_cyc.size(), 1);
        chk("done_wr_overlap", viol_done, 0);
    endtask

    initial begin
        logic [255:0] d;
        int n, nr, nw;
        rst_i = 1'b0; start_i = 1'b0; rows_i = '0; acc_base_i = '0; ub_base_i = '0;
        shift_i = '0; relu_en_i = 1'b0;
        for (int j = 0; j < 32; j++) lane_val[j] = 0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_rd_en", acc_rd_en_o, 0);
        chk("rst_rd_addr", acc_addr_rd_o, 0);
        chk("rst_wr_en", ub_wr_en_o, 0);
        chk("rst_wr_addr", ub_addr_wr_o, 0);
        chk("rst_wr_data", ub_data_o, 0);
        chk("rst_busy_done", {busy_o, done_o}, 0);
        rst_i = 1'b1;

        // basic tile, grant always high
        start_tile(4, 'h010, 'h100, 0, 1'b0);
        chk("busy_after_start", busy_o, 1);
        wait_done();
        chk("t1_rd_n", rd_cyc.size(), 4);
        chk("t1_wr_n", wr_cyc.size(), 4);
        for (int k = 0; k < 4 && k < rd_cyc.size(); k++) begin
            chk("t1_rd_cyc", rd_cyc[k], k + 1);
            chk("t1_rd_addr", rd_addr[k], 'h010 + k);
        end
        for (int k = 0; k < 4 && k < wr_cyc.size(); k++) begin
            chk("t1_wr_cyc", wr_cyc[k], k + 3);
            chk("t1_wr_addr", wr_addr[k], 'h100 + k);
            chk("t1_wr_data", wr_data[k], exp_row(k));
        end
        if (done_cyc.size() > 0) chk("t1_done_cyc", done_cyc[0], 7);
        chk("t1_idle", busy_o, 0);

        // same tile, grant low for 5 cycles on the second write
        start_tile(4, 'h010, 'h100, 0, 1'b0);
        stall_en = 1;
        wait_done();
        stall_en = 0;
        chk("st_stall_cycles", n_stall, 5);
        chk("st_stable", viol_stall, 0);
        chk("st_max_outst", max_outst, 2);
        chk("st_wr_n", wr_cyc.size(), 4);
        for (int k = 0; k < 4 && k < wr_cyc.size(); k++) begin
            chk("st_wr_addr", wr_addr[k], 'h100 + k);
            chk("st_wr_data", wr_data[k], exp_row(k));
        end
        if (wr_cyc.size() == 4) chk("st_wr_cyc", {wr_cyc[0], wr_cyc[1], wr_cyc[2], wr_cyc[3]},
                                    {32'd3, 32'd9, 32'd10, 32'd11});
        if (rd_cyc.size() == 4) chk("st_rd_cyc", {rd_cyc[0], rd_cyc[1], rd_cyc[2], rd_cyc[3]},
                                    {32'd1, 32'd2, 32'd3, 32'd9});
        if (done_cyc.size() > 0) chk("st_done_cyc", done_cyc[0], 12);

        // requantization corner values
        row_step = 0;
        lane_val[0] = -300; lane_val[1] = 100000; lane_val[2] = -100000; lane_val[3] = 7;
        start_tile(1, 'h040, 'h200, 2, 1'b0);
        wait_done();
        chk("rq_a_n", wr_data.size(), 1);
        if (wr_data.size() > 0) begin
            d = wr_data[0];
            chk("rq_a_lanes", d[31:0], 32'h01_80_7F_B5);
            chk("rq_a_rest", d[255:32], 0);
        end
        start_tile(1, 'h040, 'h200, 2, 1'b1);
        wait_done();
        if (wr_data.size() > 0) begin
            d = wr_data[0];
            chk("rq_relu_lanes", d[31:0], 32'h01_00_7F_00);
        end
        start_tile(1, 'h040, 'h200, 4, 1'b0);
        wait_done();
        if (wr_data.size() > 0) begin
            d = wr_data[0];
            chk("rq_sat_lanes", d[31:0], 32'h00_80_7F_ED);
        end
        for (int j = 0; j < 4; j++) lane_val[j] = 0;
        row_step = 1;

        // address wrap
        start_tile(3, 'h3FE, 'hFFF, 0, 1'b0);
        wait_done();
        if (rd_addr.size() == 3) chk("wrap_rd", {rd_addr[0], rd_addr[1], rd_addr[2]},
                                     {32'h3FE, 32'h3FF, 32'h000});
        else chk("wrap_rd_n", rd_addr.size(), 3);
        if (wr_addr.size() == 3) chk("wrap_wr", {wr_addr[0], wr_addr[1], wr_addr[2]},
                                     {32'hFFF, 32'h000, 32'h001});
        else chk("wrap_wr_n", wr_addr.size(), 3);
        if (wr_data.size() == 3) chk("wrap_data2", wr_data[2], exp_row(2));

        // zero rows
        start_tile(0, 'h000, 'h000, 0, 1'b0);
        wait_done();
        if (done_cyc.size() > 0) chk("z_done_cyc", done_cyc[0], 1);
        chk("z_rd_n", rd_cyc.size(), 0);
        chk("z_wr_n", wr_cyc.size(), 0);

        // start while busy is ignored
        start_tile(3, 'h080, 'h300, 0, 1'b0);
        start_i = 1'b1;
        rows_i = 8'd7;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_done();
        chk("busy_start_rd_n", rd_cyc.size(), 3);
        chk("busy_start_wr_n", wr_cyc.size(), 3);

        // reset mid-tile after two writes
        start_tile(8, 'h000, 'h020, 0, 1'b0);
        n = 0;
        while (wr_cyc.size() < 2 && n < 50) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        chk("rs_two_writes", wr_cyc.size() >= 2, 1);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("rs_outputs", {acc_rd_en_o, acc_addr_rd_o, ub_wr_en_o, ub_addr_wr_o, busy_o, done_o}, 0);
        chk("rs_data", ub_data_o, 0);
        rst_i = 1'b1;
        nr = rd_cyc.size();
        nw = wr_cyc.size();
        repeat (12) @(posedge clk_i);
        #1;
        chk("rs_no_rd", rd_cyc.size(), nr);
        chk("rs_no_wr", wr_cyc.size(), nw);
        chk("rs_no_done", done_cyc.size(), 0);
        start_tile(2, 'h005, 'h050, 0, 1'b0);
        wait_done();
        chk("rs_fresh_wr_n", wr_cyc.size(), 2);
        if (wr_addr.size() == 2) chk("rs_fresh_addr", {wr_addr[0], wr_addr[1]}, {32'h050, 32'h051});
        if (wr_data.size() == 2) chk("rs_fresh_data", wr_data[1], exp_row(1));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
